// File: rtl/sequence_loader_pkg.sv
// Shared types for the sequence loader: DNA base encoding, loader FSM states,
// whitespace byte constants and a base-to-ASCII helper used by the echo path.
package sequence_loader_pkg;

  typedef enum logic [1:0] {A, C, G, T} dna_base;

  typedef enum logic [1:0] {LOAD1, LOAD2, READY, ERROR} loader_state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  function automatic logic [7:0] base_to_ascii(input dna_base b);
    case (b)
      A:       return 8'h41;
      C:       return 8'h43;
      G:       return 8'h47;
      default: return 8'h54;
    endcase
  endfunction

endpackage

// File: rtl/ascii_base_decoder.sv
// Combinational ASCII-to-dna_base decoder; flags bases (either case) and
// the whitespace bytes that are consumed without effect.
module ascii_base_decoder
  import sequence_loader_pkg::*;
(
  input  logic [7:0] in_data,
  output dna_base    base,
  output logic       is_base,
  output logic       is_skip
);

  always_comb begin
    base    = A;
    is_base = 1'b0;
    is_skip = 1'b0;
    case (in_data)
      8'h41, 8'h61: begin base = A; is_base = 1'b1; end
      8'h43, 8'h63: begin base = C; is_base = 1'b1; end
      8'h47, 8'h67: begin base = G; is_base = 1'b1; end
      8'h54, 8'h74: begin base = T; is_base = 1'b1; end
      ASCII_LF, ASCII_CR, ASCII_SP: is_skip = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sequence_loader.sv
// Loads seq1 then seq2 from an ASCII byte stream and holds short_solver in
// reset until both are complete. Optional echo port: SEQ_LOADER_ECHO_EN.
module sequence_loader
  import sequence_loader_pkg::*;
#(
  parameter int unsigned len1 = 10,
  parameter int unsigned len2 = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 restart,
  input  logic                 solver_finished,
  output dna_base [len1-1:0]   seq1,
  output dna_base [len2-1:0]   seq2,
  output logic                 seqs_valid,
  output logic                 solver_rst,
  output logic                 load_error,
  output logic                 busy
`ifdef SEQ_LOADER_ECHO_EN
  ,
  output logic [7:0]           echo_data,
  output logic                 echo_valid
`endif
);

  localparam int unsigned LMAX = (len1 > len2) ? len1 : len2;
  localparam int unsigned CW   = $clog2(LMAX) + 1;

  loader_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wr1, wr2, xfer;
  dna_base       dec_base;
  logic          dec_is_base, dec_is_skip;

  ascii_base_decoder u_decoder (
    .in_data (in_data),
    .base    (dec_base),
    .is_base (dec_is_base),
    .is_skip (dec_is_skip)
  );

  assign in_ready   = (state == LOAD1) || (state == LOAD2);
  assign xfer       = in_valid && in_ready;
  assign seqs_valid = (state == READY);
  assign solver_rst = (state != READY);
  assign load_error = (state == ERROR);
  assign busy       = (state == READY) && !solver_finished;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr1       = 1'b0;
    wr2       = 1'b0;
    case (state)
      LOAD1: begin
        if (xfer) begin
          if (dec_is_base) begin
            wr1 = 1'b1;
            if (cnt == CW'(len1 - 1)) begin
              state_nxt = LOAD2;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else if (!dec_is_skip) begin
            state_nxt = ERROR;
          end
        end
      end
      LOAD2: begin
        if (xfer) begin
          if (dec_is_base) begin
            wr2 = 1'b1;
            if (cnt == CW'(len2 - 1)) begin
              state_nxt = READY;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else if (!dec_is_skip) begin
            state_nxt = ERROR;
          end
        end
      end
      default: begin
        if (restart) begin
          state_nxt = LOAD1;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Sequence storage is not cleared on restart; the next load overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD1;
      cnt   <= '0;
      for (int unsigned i = 0; i < len1; i++) seq1[i] <= A;
      for (int unsigned i = 0; i < len2; i++) seq2[i] <= A;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      for (int unsigned i = 0; i < len1; i++)
        if (wr1 && cnt == CW'(i)) seq1[i] <= dec_base;
      for (int unsigned i = 0; i < len2; i++)
        if (wr2 && cnt == CW'(i)) seq2[i] <= dec_base;
    end
  end

`ifdef SEQ_LOADER_ECHO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_valid <= 1'b0;
      echo_data  <= '0;
    end else begin
      echo_valid <= wr1 || wr2;
      if (wr1 || wr2) echo_data <= base_to_ascii(dec_base);
    end
  end
`endif

endmodule
